f_pcgen: RTL and testbench
==========================

F_PCGEN -- requirements
Module: f_pcgen

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 stall  in  1  hold fetch PC (hazard from later stages).
REQ-004 d_redirect  in  1  decode stage resolved a direct jump target.
REQ-005 d_target  in  13  word-address target from decode, valid with d_redirect.
REQ-006 e_fail_predict  in  1  execute-stage misprediction.
REQ-007 e_nextpc  in  13  execute-stage correct next PC, valid with e_fail_predict.
REQ-008 e_valid  in  1  execute stage holds a resolved jump/branch; triggers predictor update.
REQ-009 e_pc  in  13  word PC of the resolved instruction.
REQ-010 e_taken  in  1  resolved outcome, 1 when e_nextpc != e_pc+1.
REQ-011 pc  out  13  current fetch word address (registered).
REQ-012 pc_predicted  out  13  predicted next PC for the instruction at pc, carried down the pipeline.
REQ-013 flush  out  1  kill younger in-flight F/D instructions this cycle.

Function
REQ-014 The BTB SHALL have 16 direct-mapped entries: index pc[3:0], tag pc[12:4] (9 bits), target (13 bits), 2-bit saturating counter, valid bit.
REQ-015 pc_predicted SHALL be the entry target when valid, tag matches and counter[1]=1; otherwise pc+1 (13-bit wrap, 13'h1FFF+1 = 0).
REQ-016 pc_predicted SHALL be combinational from pc and current BTB contents; a same-cycle update SHALL NOT affect it (read-before-write).
REQ-017 Next-pc priority SHALL be: e_fail_predict -> e_nextpc; else d_redirect -> d_target; else stall -> hold; else pc_predicted.
REQ-018 e_fail_predict and d_redirect SHALL override stall.
REQ-019 flush SHALL equal e_fail_predict | d_redirect, combinational, zero latency.
REQ-020 On e_valid with tag hit: e_taken increments counter (saturate 2'b11), else decrements (saturate 2'b00); target overwritten with e_nextpc when e_taken.
REQ-021 On e_valid with miss and e_taken: allocate entry, valid=1, tag=e_pc[12:4], target=e_nextpc, counter=2'b10 (replaces any prior occupant).
REQ-022 On e_valid with miss and not e_taken: no BTB change.
REQ-023 BTB update SHALL occur on e_valid regardless of stall, d_redirect or e_fail_predict.
REQ-024 Redirect takes effect next cycle: pc equals redirect target one clock after e_fail_predict/d_redirect is sampled high.

Reset
REQ-025 rst_n low SHALL asynchronously force pc=13'd0, all BTB valid bits 0, all counters 2'b00, targets/tags 0.
REQ-026 During reset pc_predicted SHALL read 13'd1 and flush SHALL follow its inputs.
REQ-027 Reset deassertion mid-operation SHALL restart fetch from 0 with empty BTB; first fetch pc=0 on the first edge after release is held, pc=1 on the second.

Configuration
REQ-028 Macro PCGEN_STATS_EN, when defined, SHALL add outputs stat_branches (32, count of e_valid cycles) and stat_mispredicts (32, count of e_fail_predict cycles), both reset to 0, wrapping at 2^32.
REQ-029 Without PCGEN_STATS_EN those ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-030 Reset then 4 free-running cycles, no events -> pc sequence 0,1,2,3, pc_predicted = pc+1, flush=0.
REQ-031 e_valid, e_pc=5, e_taken=1, e_nextpc=20 -> entry 5 allocated counter 2'b10; later pc=5 gives pc_predicted=20.
REQ-032 Same branch resolved not-taken twice -> counter 2'b10->2'b01->2'b00; pc=5 gives pc_predicted=6; entry stays valid.
REQ-033 stall=1, d_redirect=1 d_target=40, e_fail_predict=1 e_nextpc=100 same cycle -> flush=1, next pc=100.
REQ-034 pc=13'h1FFF, empty BTB -> pc_predicted=0, next pc=0.
REQ-035 Aliasing: allocate e_pc=5 then e_pc=21 (same index) taken to 60 -> pc=5 predicts 6; pc=21 predicts 60; with PCGEN_STATS_EN stat_branches=2.

Source files
------------

// File: rtl/f_pcgen.sv
// rtl/f_pcgen.sv - fetch PC generator with a 16-entry direct-mapped BTB.
// Optional PCGEN_STATS_EN adds branch / mispredict counters.
module f_pcgen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        d_redirect,
    input  logic [12:0] d_target,
    input  logic        e_fail_predict,
    input  logic [12:0] e_nextpc,
    input  logic        e_valid,
    input  logic [12:0] e_pc,
    input  logic        e_taken,
    output logic [12:0] pc,
    output logic [12:0] pc_predicted,
    output logic        flush
`ifdef PCGEN_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int BTB_ENTRIES = 16;

    logic [12:0] r_pc;
    logic        r_run;

    logic        r_btb_valid [0:BTB_ENTRIES-1];
    logic [8:0]  r_btb_tag   [0:BTB_ENTRIES-1];
    logic [12:0] r_btb_tgt   [0:BTB_ENTRIES-1];
    logic [1:0]  r_btb_ctr   [0:BTB_ENTRIES-1];

    logic [3:0]  w_rd_idx;
    logic        w_rd_hit;
    logic [12:0] w_seq_pc;
    logic [12:0] w_next_pc;

    logic [3:0]  w_wr_idx;
    logic        w_wr_hit;
    logic        w_wr_en;
    logic [1:0]  w_wr_ctr;
    logic [12:0] w_wr_tgt;

    // Lookup reads registered BTB state only, so a same-cycle update is not visible.
    assign w_rd_idx     = r_pc[3:0];
    assign w_rd_hit     = r_btb_valid[w_rd_idx]
                          && (r_btb_tag[w_rd_idx] == r_pc[12:4])
                          && r_btb_ctr[w_rd_idx][1];
    assign w_seq_pc     = r_pc + 13'd1;
    assign pc_predicted = w_rd_hit ? r_btb_tgt[w_rd_idx] : w_seq_pc;
    assign pc           = r_pc;
    assign flush        = e_fail_predict | d_redirect;

    // r_run holds pc at 0 for the first edge after reset release.
    always_comb begin
        w_next_pc = pc_predicted;
        if (e_fail_predict)
            w_next_pc = e_nextpc;
        else if (d_redirect)
            w_next_pc = d_target;
        else if (stall || !r_run)
            w_next_pc = r_pc;
    end

    assign w_wr_idx = e_pc[3:0];
    assign w_wr_hit = r_btb_valid[w_wr_idx] && (r_btb_tag[w_wr_idx] == e_pc[12:4]);

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ctr = r_btb_ctr[w_wr_idx];
        w_wr_tgt = r_btb_tgt[w_wr_idx];
        if (e_valid) begin
            if (w_wr_hit) begin
                w_wr_en = 1'b1;
                if (e_taken) begin
                    w_wr_tgt = e_nextpc;
                    if (r_btb_ctr[w_wr_idx] != 2'b11)
                        w_wr_ctr = r_btb_ctr[w_wr_idx] + 2'b01;
                end else if (r_btb_ctr[w_wr_idx] != 2'b00) begin
                    w_wr_ctr = r_btb_ctr[w_wr_idx] - 2'b01;
                end
            end else if (e_taken) begin
                w_wr_en  = 1'b1;
                w_wr_ctr = 2'b10;
                w_wr_tgt = e_nextpc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= 13'd0;
            r_run <= 1'b0;
        end else begin
            r_pc  <= w_next_pc;
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= 9'd0;
                r_btb_tgt[i]   <= 13'd0;
                r_btb_ctr[i]   <= 2'b00;
            end
        end else if (w_wr_en) begin
            r_btb_valid[w_wr_idx] <= 1'b1;
            r_btb_tag[w_wr_idx]   <= e_pc[12:4];
            r_btb_tgt[w_wr_idx]   <= w_wr_tgt;
            r_btb_ctr[w_wr_idx]   <= w_wr_ctr;
        end
    end

`ifdef PCGEN_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (e_valid)
                r_stat_branches <= r_stat_branches + 32'd1;
            if (e_fail_predict)
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_f_pcgen.sv
// tb/tb_f_pcgen.sv - directed self-checking bench for f_pcgen.
module tb_f_pcgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        d_redirect;
    logic [12:0] d_target;
    logic        e_fail_predict;
    logic [12:0] e_nextpc;
    logic        e_valid;
    logic [12:0] e_pc;
    logic        e_taken;
    logic [12:0] pc;
    logic [12:0] pc_predicted;
    logic        flush;
`ifdef PCGEN_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    f_pcgen u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .d_redirect     (d_redirect),
        .d_target       (d_target),
        .e_fail_predict (e_fail_predict),
        .e_nextpc       (e_nextpc),
        .e_valid        (e_valid),
        .e_pc           (e_pc),
        .e_taken        (e_taken),
        .pc             (pc),
        .pc_predicted   (pc_predicted),
        .flush          (flush)
`ifdef PCGEN_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [12:0] tgt);
        d_redirect = 1'b1;
        d_target   = tgt;
        #1;
        check("redirect_flush", flush, 1);
        step();
        d_redirect = 1'b0;
        check("redirect_pc", pc, tgt);
    endtask

    task automatic resolve(input logic [12:0] bpc, input logic tk, input logic [12:0] npc);
        e_valid  = 1'b1;
        e_pc     = bpc;
        e_taken  = tk;
        e_nextpc = npc;
        step();
        e_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; d_redirect = 1'b0; d_target = '0;
        e_fail_predict = 1'b0; e_nextpc = '0; e_valid = 1'b0; e_pc = '0; e_taken = 1'b0;
        repeat (2) step();
        check("rst_pc", pc, 0);
        check("rst_pred", pc_predicted, 1);
        check("rst_flush0", flush, 0);
        d_redirect = 1'b1;
        #1 check("rst_flush_follow", flush, 1);
        d_redirect = 1'b0;

        rst_n = 1'b1;
        check("rel_pc", pc, 0);
        step();
        check("hold_pc", pc, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("free_pc", pc, i);
            check("free_pred", pc_predicted, i + 1);
            check("free_flush", flush, 0);
        end

        // Allocate 5 -> 20, then predicted at pc=5.
        resolve(13'd5, 1'b1, 13'd20);
        go_to(13'd5);
        check("alloc_pred", pc_predicted, 20);

        // Two not-taken: 10 -> 01 -> 00; one taken: 01 still not predicted.
        resolve(13'd5, 1'b0, 13'd6);
        resolve(13'd5, 1'b0, 13'd6);
        go_to(13'd5);
        check("ctr00_pred", pc_predicted, 6);
        resolve(13'd5, 1'b1, 13'd20);
        go_to(13'd5);
        check("ctr01_pred", pc_predicted, 6);
        resolve(13'd5, 1'b1, 13'd20);
        go_to(13'd5);
        check("ctr10_pred", pc_predicted, 20);

        // Saturate at 11 then one not-taken leaves 10.
        resolve(13'd5, 1'b1, 13'd20);
        resolve(13'd5, 1'b1, 13'd20);
        resolve(13'd5, 1'b0, 13'd6);
        go_to(13'd5);
        check("sat11_pred", pc_predicted, 20);

        // Hit taken overwrites target.
        resolve(13'd5, 1'b1, 13'd30);
        go_to(13'd5);
        check("retarget_pred", pc_predicted, 30);

        // Same-cycle update does not affect the current prediction.
        e_valid = 1'b1; e_pc = 13'd5; e_taken = 1'b1; e_nextpc = 13'd33;
        #1 check("rbw_pred", pc_predicted, 30);
        step();
        e_valid = 1'b0;
        check("rbw_pc", pc, 30);
        go_to(13'd5);
        check("rbw_newtgt", pc_predicted, 33);

        // Priority: fail_predict over d_redirect over stall.
        stall = 1'b1; d_redirect = 1'b1; d_target = 13'd40;
        e_fail_predict = 1'b1; e_nextpc = 13'd100;
        #1 check("prio_flush", flush, 1);
        step();
        check("prio_pc", pc, 100);
        e_fail_predict = 1'b0;
        step();
        check("dred_over_stall", pc, 40);
        d_redirect = 1'b0;
        #1 check("stall_flush0", flush, 0);
        step();
        check("stall_hold", pc, 40);
        stall = 1'b0;

        // Wrap at 13'h1FFF.
        go_to(13'h1FFF);
        check("wrap_pred", pc_predicted, 0);
        step();
        check("wrap_pc", pc, 0);

        // Miss not-taken leaves BTB alone; aliasing replaces occupant.
        resolve(13'd7, 1'b0, 13'd8);
        go_to(13'd7);
        check("miss_nt_pred", pc_predicted, 8);
        resolve(13'd21, 1'b1, 13'd60);
        go_to(13'd5);
        check("alias_5_pred", pc_predicted, 6);
        go_to(13'd21);
        check("alias_21_pred", pc_predicted, 60);

        // Asynchronous reset mid-cycle clears pc and BTB.
        #3 rst_n = 1'b0;
        #1 check("async_rst_pc", pc, 0);
        check("async_rst_pred", pc_predicted, 1);
        step();
        rst_n = 1'b1;
        step();
        check("rerun_hold", pc, 0);
        step();
        check("rerun_pc1", pc, 1);
        go_to(13'd21);
        check("rerun_btb_empty", pc_predicted, 22);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
